// File: rtl/wts_bus_bridge.sv
// ============================================================================
// Module   : wts_bus_bridge
// Purpose  : OCM slot bus to wave-table core bridge with RAM handshake,
//            core register access and attenuated audio output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wts_bus_bridge #(
    parameter int RD_LATENCY  = 10,
    parameter int RAM_TIMEOUT = 64,
    parameter int RAM_AW      = 21,
    parameter int CORE_W      = 12,
    parameter int WAV_W       = 15
) (
    input  logic                clk21m,
    input  logic                reset,
    input  logic                req,
    input  logic                wrt,
    input  logic [15:0]         adr,
    input  logic [7:0]          dbo,
    output logic [7:0]          dbi,
    output logic                ack,
    output logic                err,
    output logic                ramreq,
    input  logic                ramack,
    output logic                ramwrt,
    output logic [RAM_AW-1:0]   ramadr,
    input  logic [7:0]          ramdbi,
    output logic [7:0]          ramdbo,
    output logic                core_wrreq,
    output logic                core_rdreq,
    output logic                core_wr_active,
    output logic                core_rd_active,
    input  logic [7:0]          core_q,
    input  logic                core_mem_ncs,
    input  logic [RAM_AW-14:0]  core_mem_a,
    input  logic [CORE_W-1:0]   core_left,
    input  logic [CORE_W-1:0]   core_right,
    input  logic                sw_mono,
    input  logic [2:0]          vol,
    output logic [WAV_W-1:0]    wavl,
    output logic [WAV_W-1:0]    wavr
);

    localparam int c_SH = WAV_W - CORE_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAM  = 3'd1,
        ST_CRD  = 3'd2,
        ST_CWR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [12:0]         r_adr;
    logic [RAM_AW-14:0]  r_mem_a;
    logic                r_wrt;
    logic [7:0]          r_dbo;
    logic                w_ram_tmo;
    logic                w_unused;

    // Upper bus address bits are decoded by the core, not by the bridge.
    assign w_unused = ^adr[15:13];

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        core_wrreq = 1'b0;
        core_rdreq = 1'b0;
        w_ram_tmo  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req && !reset) begin
                    if (!core_mem_ncs) begin
                        w_next = ST_RAM;
                    end else if (wrt) begin
                        w_next     = ST_CWR;
                        core_wrreq = 1'b1;
                    end else begin
                        w_next     = ST_CRD;
                        core_rdreq = 1'b1;
                    end
                end
            end
            ST_RAM: begin
                // An ack in the expiry clock wins over the timeout.
                if (ramack) begin
                    w_next = ST_DONE;
                end else if (r_cnt <= 8'd1) begin
                    w_next    = ST_DONE;
                    w_ram_tmo = 1'b1;
                end
            end
            ST_CRD:  if (r_cnt == 8'd0) w_next = ST_DONE;
            ST_CWR:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            r_cnt          <= 8'd0;
            r_adr          <= '0;
            r_mem_a        <= '0;
            r_wrt          <= 1'b0;
            r_dbo          <= 8'd0;
            dbi            <= 8'h00;
            ack            <= 1'b0;
            err            <= 1'b0;
            ramreq         <= 1'b0;
            core_rd_active <= 1'b0;
            core_wr_active <= 1'b0;
        end else begin
            ack            <= (w_next == ST_DONE);
            core_rd_active <= (w_next == ST_CRD) || (w_next == ST_DONE && r_state == ST_CRD);
            core_wr_active <= (w_next == ST_CWR) || (w_next == ST_DONE && r_state == ST_CWR);
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_RAM) begin
                        r_adr   <= adr[12:0];
                        r_mem_a <= core_mem_a;
                        r_wrt   <= wrt;
                        r_dbo   <= dbo;
                        ramreq  <= 1'b1;
                        r_cnt   <= 8'(RAM_TIMEOUT);
                    end else if (w_next == ST_CRD) begin
                        r_cnt   <= 8'(RD_LATENCY - 1);
                    end
                end
                ST_RAM: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (ramack) begin
                        ramreq <= 1'b0;
                        if (!r_wrt) dbi <= ramdbi;
                    end else if (w_ram_tmo) begin
                        ramreq <= 1'b0;
                        err    <= 1'b1;
                        if (!r_wrt) dbi <= 8'hFF;
                    end
                end
                ST_CRD: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd0) dbi <= core_q;
                end
                default: ;
            endcase
        end
    end

    assign ramwrt = r_wrt;
    assign ramdbo = r_dbo;
    assign ramadr = {r_mem_a, r_adr};

    // Audio path: scale to output width, mono sum keeps its carry bit.
    logic [CORE_W:0]   w_mix;
    logic [WAV_W-1:0]  w_l_sc;
    logic [WAV_W-1:0]  w_r_sc;
    logic [WAV_W-1:0]  w_m_sc;

    assign w_mix  = {1'b0, core_left} + {1'b0, core_right};
    assign w_l_sc = WAV_W'(core_left) << c_SH;
    assign w_r_sc = WAV_W'(core_right) << c_SH;
    assign w_m_sc = WAV_W'(w_mix) << (c_SH - 1);

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            wavl <= '0;
            wavr <= '0;
        end else if (sw_mono) begin
            wavl <= w_m_sc >> vol;
            wavr <= w_m_sc >> vol;
        end else begin
            wavl <= w_l_sc >> vol;
            wavr <= w_r_sc >> vol;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wts_bus_bridge.sv
// ============================================================================
// Module   : tb_wts_bus_bridge
// Purpose  : Self-checking bench for wts_bus_bridge against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wts_bus_bridge;

    localparam int c_RD_LAT  = 10;
    localparam int c_TIMEOUT = 6;
    localparam int c_AW      = 21;
    localparam int c_CW      = 12;
    localparam int c_WW      = 15;
    localparam int c_SH      = c_WW - c_CW;

    logic              clk21m;
    logic              reset;
    logic              req;
    logic              wrt;
    logic [15:0]       adr;
    logic [7:0]        dbo;
    logic [7:0]        dbi;
    logic              ack;
    logic              err;
    logic              ramreq;
    logic              ramack;
    logic              ramwrt;
    logic [c_AW-1:0]   ramadr;
    logic [7:0]        ramdbi;
    logic [7:0]        ramdbo;
    logic              core_wrreq;
    logic              core_rdreq;
    logic              core_wr_active;
    logic              core_rd_active;
    logic [7:0]        core_q;
    logic              core_mem_ncs;
    logic [c_AW-14:0]  core_mem_a;
    logic [c_CW-1:0]   core_left;
    logic [c_CW-1:0]   core_right;
    logic              sw_mono;
    logic [2:0]        vol;
    logic [c_WW-1:0]   wavl;
    logic [c_WW-1:0]   wavr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] m_dbi = 8'h00;
    logic       m_err = 1'b0;

    wts_bus_bridge #(
        .RD_LATENCY (c_RD_LAT),
        .RAM_TIMEOUT(c_TIMEOUT),
        .RAM_AW     (c_AW),
        .CORE_W     (c_CW),
        .WAV_W      (c_WW)
    ) dut (
        .clk21m        (clk21m),
        .reset         (reset),
        .req           (req),
        .wrt           (wrt),
        .adr           (adr),
        .dbo           (dbo),
        .dbi           (dbi),
        .ack           (ack),
        .err           (err),
        .ramreq        (ramreq),
        .ramack        (ramack),
        .ramwrt        (ramwrt),
        .ramadr        (ramadr),
        .ramdbi        (ramdbi),
        .ramdbo        (ramdbo),
        .core_wrreq    (core_wrreq),
        .core_rdreq    (core_rdreq),
        .core_wr_active(core_wr_active),
        .core_rd_active(core_rd_active),
        .core_q        (core_q),
        .core_mem_ncs  (core_mem_ncs),
        .core_mem_a    (core_mem_a),
        .core_left     (core_left),
        .core_right    (core_right),
        .sw_mono       (sw_mono),
        .vol           (vol),
        .wavl          (wavl),
        .wavr          (wavr)
    );

    initial clk21m = 1'b0;
    always #5 clk21m = ~clk21m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk21m);
        #1;
    endtask

    // Expected sample: scale to output width, then attenuate by 2**vol.
    function automatic int exp_wav(input bit mono, input int l, input int r, input int v, input bit left);
        int base;
        if (mono) base = (l + r) * (1 << (c_SH - 1));
        else      base = (left ? l : r) * (1 << c_SH);
        return base / (1 << v);
    endfunction

    // One bus transaction; ack_at is the clock ramack is driven (<=0: never).
    task automatic run_txn(input bit t_wrt, input bit t_ncs, input logic [15:0] t_adr,
                           input logic [7:0] t_dbo, input logic [7:0] t_q,
                           input logic [7:0] t_ramdbi, input logic [7:0] t_bank,
                           input int ack_at, input bit hold);
        int exp_ack;
        bit tmo;
        tmo = 1'b0;
        if (!t_ncs) begin
            if (ack_at >= 1 && ack_at <= c_TIMEOUT) exp_ack = ack_at + 1;
            else begin
                exp_ack = c_TIMEOUT + 1;
                tmo     = 1'b1;
            end
        end else begin
            exp_ack = t_wrt ? 2 : c_RD_LAT + 1;
        end
        req = 1'b1; wrt = t_wrt; adr = t_adr; dbo = t_dbo; core_q = t_q;
        core_mem_ncs = t_ncs; core_mem_a = t_bank; ramdbi = t_ramdbi; ramack = 1'b0;
        #1;
        check("wrreq_strobe", core_wrreq, t_ncs & t_wrt);
        check("rdreq_strobe", core_rdreq, t_ncs & ~t_wrt);
        tick();
        for (int c = 1; c <= exp_ack + 1; c++) begin
            req    = hold && (c < exp_ack);
            wrt    = 1'($urandom);
            ramack = !t_ncs && (c == ack_at);
            if (c == 1 && !t_ncs) begin
                check("ramadr", ramadr, t_bank * (1 << 13) + (t_adr % 8192));
                check("ramwrt", ramwrt, t_wrt);
                check("ramdbo", ramdbo, t_dbo);
            end
            #1;
            check("ack", ack, c == exp_ack);
            check("wrreq_idle", core_wrreq, 0);
            check("rdreq_idle", core_rdreq, 0);
            if (!t_ncs) check("ramreq", ramreq, c < exp_ack);
            check("rd_active", core_rd_active, t_ncs && !t_wrt && c <= exp_ack);
            check("wr_active", core_wr_active, t_ncs && t_wrt && c <= exp_ack);
            tick();
        end
        ramack = 1'b0;
        if (!t_wrt) m_dbi = t_ncs ? t_q : (tmo ? 8'hFF : t_ramdbi);
        if (tmo) m_err = 1'b1;
        check("dbi", dbi, m_dbi);
        check("err", err, m_err);
    endtask

    task automatic audio(input bit mono, input logic [c_CW-1:0] l, input logic [c_CW-1:0] r, input logic [2:0] v);
        sw_mono = mono; core_left = l; core_right = r; vol = v;
        tick();
        check("wavl", wavl, exp_wav(mono, l, r, v, 1'b1));
        check("wavr", wavr, exp_wav(mono, l, r, v, 1'b0));
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wrt = 1'b0; adr = 16'h0; dbo = 8'h0;
        ramack = 1'b0; ramdbi = 8'h0; core_q = 8'h0; core_mem_ncs = 1'b1;
        core_mem_a = '0; core_left = 12'h123; core_right = 12'h456; sw_mono = 1'b0; vol = 3'd0;
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_ramreq", ramreq, 0);
        check("rst_err", err, 0);
        check("rst_dbi", dbi, 8'h00);
        check("rst_wavl", wavl, 0);
        check("rst_wavr", wavr, 0);
        check("rst_actives", {core_rd_active, core_wr_active}, 0);
        reset = 1'b0;
        tick();

        run_txn(1'b0, 1'b1, 16'h4010, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 1'b0);
        run_txn(1'b1, 1'b1, 16'h4011, 8'h3C, 8'h99, 8'h00, 8'h00, 0, 1'b0);
        run_txn(1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 8'hC3, 8'h81, 5, 1'b0);
        run_txn(1'b0, 1'b0, 16'hABCD, 8'h00, 8'h00, 8'h6E, 8'h17, c_TIMEOUT, 1'b0);
        run_txn(1'b0, 1'b0, 16'h0F0F, 8'h00, 8'h00, 8'h11, 8'h02, 0, 1'b0);
        run_txn(1'b1, 1'b0, 16'h2222, 8'hA5, 8'h00, 8'h00, 8'h40, 2, 1'b0);
        run_txn(1'b0, 1'b1, 16'h4020, 8'h00, 8'h77, 8'h00, 8'h00, 0, 1'b1);

        // Abort a RAM wait with reset; sticky err must clear.
        req = 1'b1; wrt = 1'b0; core_mem_ncs = 1'b0; ramack = 1'b0;
        tick();
        req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ramreq", ramreq, 0);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_err", err, 0);
        m_err = 1'b0;
        m_dbi = 8'h00;
        tick();
        reset = 1'b0;
        tick();
        run_txn(1'b0, 1'b1, 16'h4030, 8'h00, 8'hE7, 8'h00, 8'h00, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int ak;
            ak = int'($urandom_range(0, c_TIMEOUT + 2));
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), ak, 1'($urandom));
        end

        audio(1'b0, 12'hFFF, 12'h001, 3'd0);
        check("wavl_direct", wavl, 15'h7FF8);
        check("wavr_direct", wavr, 15'h0008);
        audio(1'b1, 12'hFFF, 12'h001, 3'd0);
        check("mono_direct", wavl, 15'h4000);
        audio(1'b1, 12'hFFF, 12'h001, 3'd3);
        check("mono_vol3", wavr, 15'h0800);
        audio(1'b1, 12'hFFF, 12'hFFF, 3'd0);
        audio(1'b0, 12'hFFF, 12'hFFF, 3'd7);
        for (int i = 0; i < 40; i++) begin
            audio(1'($urandom), 12'($urandom), 12'($urandom), 3'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
